diagnostics_ctrl: RTL and testbench

SPI-slave diagnostics controller for the ROMulator FPGA. Once the flash image is loaded, an external host can use it over SPI to halt the CPU, read and write the 64 KB RAM image, read back video RAM, and select the memory configuration and RAM/ROM disable flags. Its outputs drive the RAM bus multiplexer (active while `halt`=1), the VRAM read port and the enable-table configuration.

---
 rtl/diag_pkg.sv | 22 ++
 rtl/diag_spi_slave.sv | 61 ++++++
 rtl/diagnostics_ctrl.sv | 176 +++++++++++++++++
 tb/tb_diagnostics_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/diag_pkg.sv
// diag_pkg: opcodes, command FSM states and MISO constants shared by the diagnostics controller.
package diag_pkg;
    localparam logic [7:0] OP_HALT        = 8'h01;
    localparam logic [7:0] OP_RUN         = 8'h02;
    localparam logic [7:0] OP_READ        = 8'h03;
    localparam logic [7:0] OP_WRITE       = 8'h04;
    localparam logic [7:0] OP_VRAM        = 8'h05;
    localparam logic [7:0] OP_SET_CONFIG  = 8'h06;
    localparam logic [7:0] OP_SET_DISABLE = 8'h07;
    localparam logic [7:0] OP_GET_CONFIG  = 8'h08;
    localparam logic [7:0] MISO_IDLE      = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_READ_STREAM,
        S_WRITE_STREAM, S_VRAM_STREAM, S_ARG, S_DONE
    } state_e;

    function automatic logic [7:0] status_byte(input logic halt, input logic ram_dis,
                                               input logic rom_dis, input logic [4:0] cfg);
        return {halt, ram_dis, rom_dis, cfg};
    endfunction
endpackage

// File: rtl/diag_spi_slave.sv
// diag_spi_slave: SPI mode-0 slave; synchronizes CS/SCK/MOSI into clk, assembles bytes MSB first
// and shifts MISO from a byte loaded by the command logic.
module diag_spi_slave (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       load_tx,
    input  logic [7:0] tx_data,
    output logic       cs_active,
    output logic       frame_start,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);
    import diag_pkg::*;

    // bits [1:0] are the synchronizer, bit [2] the previous synchronized value
    logic [2:0] cs_q, cs_d, sck_q, sck_d;
    logic [1:0] mosi_q, mosi_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d;
    logic       sck_rise, sck_fall;

    always_comb begin
        cs_d        = {cs_q[1:0], spi_cs};
        sck_d       = {sck_q[1:0], spi_sck};
        mosi_d      = {mosi_q[0], spi_mosi};
        cs_active   = ~cs_q[1];
        frame_start = cs_q[2] & ~cs_q[1];
        sck_rise    = cs_active & sck_q[1] & ~sck_q[2];
        sck_fall    = cs_active & ~sck_q[1] & sck_q[2];
        rx_byte     = {rx_q[6:0], mosi_q[1]};
        byte_valid  = sck_rise & (bit_cnt_q == 3'd7);
        rx_d        = sck_rise ? rx_byte : rx_q;
        bit_cnt_d   = !cs_active ? 3'd0 : sck_rise ? bit_cnt_q + 3'd1 : bit_cnt_q;
        // the fall after the 8th bit leaves the register alone so the next byte can be loaded
        tx_d        = load_tx ? tx_data
                    : (sck_fall && bit_cnt_q != 3'd0) ? {tx_q[6:0], 1'b1} : tx_q;
        spi_miso    = tx_q[7];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q      <= 3'b111;
            sck_q     <= '0;
            mosi_q    <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= MISO_IDLE;
        end else begin
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
        end
    end
endmodule

// File: rtl/diagnostics_ctrl.sv
// diagnostics_ctrl: SPI-driven halt, RAM read/write, VRAM readback and config control.
// Define DIAG_VRAM_READ_EN to implement the VRAM streaming opcode.
module diagnostics_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        halt,
    output logic [15:0] ram_addr,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_cs,
    input  logic [4:0]  configuration,
    output logic [10:0] vram_addr,
    input  logic [7:0]  vram_rdata,
    output logic        vram_clk,
    output logic [4:0]  config_byte,
    input  logic [10:0] vram_size,
    input  logic        ram_disable_in,
    input  logic        rom_disable_in,
    output logic        ram_disable_out,
    output logic        rom_disable_out
);
    import diag_pkg::*;

`ifdef DIAG_VRAM_READ_EN
    localparam bit VRAM_EN = 1'b1;
`else
    localparam bit VRAM_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d, wdata_q, wdata_d;
    logic [15:0] addr_q, addr_d;
    logic [10:0] vram_addr_q, vram_addr_d, vram_next;
    logic [4:0]  cfg_q, cfg_d;
    logic [1:0]  pend_q, pend_d;
    logic        halt_q, halt_d, ram_cs_q, ram_cs_d, ram_we_q, ram_we_d;
    logic        ram_dis_q, ram_dis_d, rom_dis_q, rom_dis_d;
    logic        fetch, load_tx, cs_active, frame_start, byte_valid;
    logic [7:0]  tx_data, rx_byte;

    diag_spi_slave u_spi (
        .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .load_tx(load_tx), .tx_data(tx_data), .cs_active(cs_active),
        .frame_start(frame_start), .byte_valid(byte_valid), .rx_byte(rx_byte)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        halt_d      = halt_q;
        addr_d      = ram_we_q ? addr_q + 16'd1 : addr_q;
        wdata_d     = wdata_q;
        ram_cs_d    = 1'b0;
        ram_we_d    = 1'b0;
        vram_addr_d = vram_addr_q;
        cfg_d       = cfg_q;
        ram_dis_d   = ram_dis_q;
        rom_dis_d   = rom_dis_q;
        fetch       = 1'b0;
        vram_next   = vram_addr_q + 11'd1;
        // prefetched data lands two cycles after the fetch, then the address advances
        load_tx     = pend_q[1];
        tx_data     = (state_q == S_VRAM_STREAM) ? vram_rdata : ram_rdata;
        if (pend_q[1] && state_q == S_READ_STREAM) addr_d = addr_q + 16'd1;
        if (pend_q[1] && state_q == S_VRAM_STREAM) vram_addr_d = (vram_next >= vram_size) ? '0 : vram_next;
        if (frame_start) begin
            load_tx = 1'b1;
            tx_data = status_byte(halt_q, ram_dis_q, rom_dis_q, cfg_q);
        end
        if (!cs_active) begin
            state_d = S_IDLE;
        end else if (byte_valid) begin
            load_tx = 1'b1;
            tx_data = MISO_IDLE;
            case (state_q)
                S_IDLE: begin
                    op_d    = rx_byte;
                    state_d = S_DONE;
                    case (rx_byte)
                        OP_HALT:                       halt_d = 1'b1;
                        OP_RUN:                        halt_d = 1'b0;
                        OP_READ, OP_WRITE:             state_d = halt_q ? S_ADDR_HI : S_DONE;
                        OP_SET_CONFIG, OP_SET_DISABLE: state_d = S_ARG;
                        OP_GET_CONFIG:                 tx_data = {3'b000, cfg_q};
                        OP_VRAM: if (VRAM_EN) begin
                            state_d     = S_VRAM_STREAM;
                            vram_addr_d = '0;
                            fetch       = 1'b1;
                            load_tx     = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_ADDR_HI: begin
                    addr_d[15:8] = rx_byte;
                    state_d      = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_d[7:0] = rx_byte;
                    state_d     = (op_q == OP_READ) ? S_READ_STREAM : S_WRITE_STREAM;
                    fetch       = (op_q == OP_READ);
                    ram_cs_d    = (op_q == OP_READ);
                    load_tx     = (op_q != OP_READ);
                end
                S_READ_STREAM: begin
                    fetch    = 1'b1;
                    ram_cs_d = 1'b1;
                    load_tx  = 1'b0;
                end
                S_VRAM_STREAM: begin
                    fetch   = 1'b1;
                    load_tx = 1'b0;
                end
                S_WRITE_STREAM: begin
                    wdata_d  = rx_byte;
                    ram_cs_d = 1'b1;
                    ram_we_d = 1'b1;
                end
                S_ARG: begin
                    state_d   = S_DONE;
                    cfg_d     = (op_q == OP_SET_CONFIG) ? rx_byte[4:0] : cfg_q;
                    ram_dis_d = (op_q == OP_SET_DISABLE) ? rx_byte[0] : ram_dis_q;
                    rom_dis_d = (op_q == OP_SET_DISABLE) ? rx_byte[1] : rom_dis_q;
                end
                default: ;
            endcase
        end
        pend_d = {pend_q[0], fetch};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            halt_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            vram_addr_q <= '0;
            cfg_q       <= configuration;
            ram_dis_q   <= ram_disable_in;
            rom_dis_q   <= rom_disable_in;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            halt_q      <= halt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            vram_addr_q <= vram_addr_d;
            cfg_q       <= cfg_d;
            ram_dis_q   <= ram_dis_d;
            rom_dis_q   <= rom_dis_d;
            pend_q      <= pend_d;
        end
    end

    assign halt            = halt_q;
    assign ram_addr        = addr_q;
    assign ram_wdata       = wdata_q;
    assign ram_we          = ram_we_q;
    assign ram_cs          = ram_cs_q;
    assign vram_addr       = VRAM_EN ? vram_addr_q : '0;
    assign vram_clk        = clk;
    assign config_byte     = cfg_q;
    assign ram_disable_out = ram_dis_q;
    assign rom_disable_out = rom_dis_q;
endmodule

// File: tb/tb_diagnostics_ctrl.sv
// tb_diagnostics_ctrl: drives SPI frames and checks results against a behavioural model of the
// diagnostics command set (RAM image, config/disable flags, halt state).
module tb_diagnostics_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        spi_cs = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0, spi_miso;
    logic        halt, ram_we, ram_cs, vram_clk, ram_disable_out, rom_disable_out;
    logic [15:0] ram_addr;
    logic [7:0]  ram_rdata, ram_wdata, vram_rdata;
    logic [10:0] vram_addr, vram_size = 11'd5;
    logic [4:0]  configuration = 5'h0A, config_byte;
    logic        ram_disable_in = 1'b1, rom_disable_in = 1'b0;

    diagnostics_ctrl dut (
        .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .halt(halt), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_cs(ram_cs), .configuration(configuration),
        .vram_addr(vram_addr), .vram_rdata(vram_rdata), .vram_clk(vram_clk),
        .config_byte(config_byte), .vram_size(vram_size), .ram_disable_in(ram_disable_in),
        .rom_disable_in(rom_disable_in), .ram_disable_out(ram_disable_out),
        .rom_disable_out(rom_disable_out)
    );

    always #5 clk = ~clk;

    // RAM and VRAM attached to the DUT
    logic [7:0] mem [0:65535];
    logic [7:0] vram [0:2047];
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_cs && !ram_we) ram_rdata <= mem[ram_addr];
        vram_rdata <= vram[vram_addr];
    end

    logic [24:0] bus_log [$];
    always @(negedge clk) if (ram_cs) bus_log.push_back({ram_we, ram_addr, ram_wdata});

    // behavioural model
    logic       m_halt = 1'b0, m_ramd = 1'b1, m_romd = 1'b0;
    logic [4:0] m_cfg = 5'h0A;
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] txq [$], rxq [$], wdat [$];
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            #50;
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame();
        logic [7:0] r, exp_status;
        exp_status = {m_halt, m_ramd, m_romd, m_cfg};
        rxq.delete();
        spi_cs = 1'b0;
        #100;
        foreach (txq[i]) begin
            spi_bits(txq[i], 8, r);
            rxq.push_back(r);
        end
        #100;
        spi_cs = 1'b1;
        #200;
        check("status", 32'(rxq[0]), 32'(exp_status));
    endtask

    task automatic run_halt(input logic h);
        txq.delete();
        txq.push_back(h ? 8'h01 : 8'h02);
        frame();
        m_halt = h;
        check("halt", 32'(halt), 32'(m_halt));
    endtask

    task automatic do_write(input logic [15:0] a);
        logic [15:0] wa;
        txq.delete();
        txq.push_back(8'h04); txq.push_back(a[15:8]); txq.push_back(a[7:0]);
        foreach (wdat[i]) txq.push_back(wdat[i]);
        bus_log.delete();
        frame();
        for (int i = 1; i < rxq.size(); i++) check("write_miso", 32'(rxq[i]), 32'hFF);
        check("write_count", bus_log.size(), m_halt ? wdat.size() : 0);
        if (m_halt) foreach (wdat[i]) begin
            wa = a + 16'(i);
            check("write_bus", 32'(bus_log[i]), 32'({1'b1, wa, wdat[i]}));
            ref_mem[wa] = wdat[i];
        end
    endtask

    task automatic do_read(input logic [15:0] a, input int n);
        logic [15:0] ra;
        txq.delete();
        txq.push_back(8'h03); txq.push_back(a[15:8]); txq.push_back(a[7:0]);
        for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
        bus_log.delete();
        frame();
        check("read_addr_miso", 32'({rxq[1], rxq[2]}), 32'hFFFF);
        for (int i = 0; i < n; i++) begin
            ra = a + 16'(i);
            check("read_data", 32'(rxq[3 + i]), m_halt ? 32'(ref_mem[ra]) : 32'hFF);
        end
        if (!m_halt) check("read_no_cs", bus_log.size(), 0);
    endtask

    task automatic set_config(input logic [7:0] v);
        txq.delete(); txq.push_back(8'h06); txq.push_back(v);
        frame();
        m_cfg = v[4:0];
        check("config_byte", 32'(config_byte), 32'(m_cfg));
    endtask

    task automatic set_disable(input logic [7:0] v);
        txq.delete(); txq.push_back(8'h07); txq.push_back(v);
        frame();
        m_ramd = v[0];
        m_romd = v[1];
        check("disables", 32'({ram_disable_out, rom_disable_out}), 32'({m_ramd, m_romd}));
    endtask

    task automatic get_config();
        txq.delete(); txq.push_back(8'h08); txq.push_back(8'($urandom)); txq.push_back(8'($urandom));
        frame();
        check("get_config", 32'(rxq[1]), 32'({3'b000, m_cfg}));
        check("get_config_tail", 32'(rxq[2]), 32'hFF);
    endtask

    initial begin
        logic [7:0]  r;
        logic [15:0] last_a;
        int          n;
        foreach (vram[i]) vram[i] = 8'($urandom);
        last_a = 16'h1234;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_config", 32'(config_byte), 32'h0A);
        check("rst_flags", 32'({halt, ram_disable_out, rom_disable_out}), 32'b010);
        check("rst_bus", 32'({ram_cs, ram_we, ram_addr, ram_wdata}), 32'h0);
        check("rst_vram_miso", 32'({vram_addr, spi_miso}), 32'h1);

        run_halt(1'b1);
        run_halt(1'b0);
        do_read(16'h1234, 2);
        wdat = {8'h5A};
        do_write(16'h2000);

        run_halt(1'b1);
        wdat = {8'hAA, 8'hBB};
        do_write(16'h1234);
        do_read(16'h1234, 2);

        set_config(8'h13);
        get_config();
        set_disable(8'h02);

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 4))
                0: run_halt(1'b1);
                1: run_halt(1'b0);
                2: begin
                    last_a = 16'($urandom);
                    wdat.delete();
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) wdat.push_back(8'($urandom));
                    if (!m_halt) last_a = 16'h1234;
                    do_write(last_a);
                end
                3: do_read(last_a, $urandom_range(1, 3));
                default: set_config(8'($urandom));
            endcase
        end

        run_halt(1'b1);
        txq.delete();
        txq.push_back(8'h04); txq.push_back(8'hFF); txq.push_back(8'hFF);
        txq.push_back(8'h11); txq.push_back(8'h22);
        bus_log.delete();
        spi_cs = 1'b0;
        #100;
        foreach (txq[i]) spi_bits(txq[i], 8, r);
        spi_bits(8'h33, 4, r);
        #100;
        spi_cs = 1'b1;
        #200;
        check("wrap_count", bus_log.size(), 2);
        check("wrap_first", 32'(bus_log[0]), 32'({1'b1, 16'hFFFF, 8'h11}));
        check("wrap_second", 32'(bus_log[1]), 32'({1'b1, 16'h0000, 8'h22}));
        ref_mem[16'hFFFF] = 8'h11;
        ref_mem[16'h0000] = 8'h22;
        do_read(16'hFFFF, 2);

        txq.delete(); txq.push_back(8'h5A); txq.push_back(8'h01); txq.push_back(8'h02);
        frame();
        check("unknown_op", 32'({rxq[1], rxq[2]}), 32'hFFFF);
        check("unknown_op_halt", 32'(halt), 32'(m_halt));

`ifdef DIAG_VRAM_READ_EN
        vram_size = 11'($urandom_range(3, 9));
        txq.delete(); txq.push_back(8'h05);
        for (int i = 0; i < 12; i++) txq.push_back(8'h00);
        frame();
        for (int i = 0; i < 12; i++) check("vram_data", 32'(rxq[1 + i]), 32'(vram[i % vram_size]));
`else
        txq.delete(); txq.push_back(8'h05); txq.push_back(8'h00); txq.push_back(8'h00);
        frame();
        check("vram_disabled", 32'({rxq[1], rxq[2]}), 32'hFFFF);
        check("vram_addr_tied", 32'(vram_addr), 32'h0);
`endif

        set_config(8'h1F);
        spi_cs = 1'b0;
        #100;
        spi_bits(8'h06, 8, r);
        spi_bits(8'h00, 4, r);
        reset = 1'b1;
        #30;
        reset = 1'b0;
        #10;
        m_halt = 1'b0; m_cfg = configuration; m_ramd = ram_disable_in; m_romd = rom_disable_in;
        check("midreset_halt", 32'(halt), 32'(m_halt));
        check("midreset_config", 32'(config_byte), 32'(m_cfg));
        check("midreset_flags", 32'({ram_disable_out, rom_disable_out}), 32'({m_ramd, m_romd}));
        #100;
        spi_cs = 1'b1;
        #200;
        run_halt(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
